// File: rtl/ch0re_div.sv
// RV64M divide/remainder (DIV/DIVU/REM/REMU + W forms), radix-2 restoring, one quotient bit per cycle.
// Latency: N+1 edges after accept (N=64, or 32 for W); 1 edge for divide-by-zero/overflow (and early-out).
// Backpressure: o_ready only in IDLE; result held in DONE until i_ready; i_flush drops work. Option: CH0RE_DIV_EARLY_OUT_EN.
module ch0re_div #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic            i_i64,
    input  logic [XLEN-1:0] i_s1,
    input  logic [XLEN-1:0] i_s2,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_res
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] X_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] W_MIN = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nx;
    logic [1:0]        op_q;
    logic              w_q, negq, negr;
    logic [XLEN-1:0]   dvs, quo, rem, res_q;
    logic [CW-1:0]     cnt;

    logic              sgn, a_neg, b_neg, div0, ovf, early, fast, accept;
    logic [XLEN-1:0]   a, b, a_mag, b_mag, fast_q, fast_r;
    logic [XLEN:0]     rem_sh;
    logic              ge;
    logic [XLEN-1:0]   rem_nx, q_fix, r_fix, sel, res_nx;

    assign accept  = i_valid && (state == IDLE) && !i_flush;
    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign o_res   = res_q;

    // Operand preparation and special-case detection on the raw request.
    always_comb begin
        sgn = ~i_op[0];
        a   = i_s1;
        b   = i_s2;
        if (i_i64) begin
            a = {{(XLEN-32){sgn & i_s1[31]}}, i_s1[31:0]};
            b = {{(XLEN-32){sgn & i_s2[31]}}, i_s2[31:0]};
        end
        a_neg = sgn & a[XLEN-1];
        b_neg = sgn & b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        div0  = (b == '0);
        ovf   = sgn && (b == '1) && (a == (i_i64 ? W_MIN : X_MIN));
`ifdef CH0RE_DIV_EARLY_OUT_EN
        early = !div0 && (a_mag < b_mag);
`else
        early = 1'b0;
`endif
        fast  = div0 | ovf | early;
        // Fast results are parked in quo/rem so the common finalize step serves them too.
        fast_q = '1;
        fast_r = a;
        if (ovf) begin
            fast_q = a;
            fast_r = '0;
        end else if (early) begin
            fast_q = '0;
            fast_r = a;
        end
    end

    // One restoring step plus final sign correction / width selection.
    always_comb begin
        rem_sh = {rem, quo[XLEN-1]};
        ge     = (rem_sh >= {1'b0, dvs});
        rem_nx = ge ? (rem_sh[XLEN-1:0] - dvs) : rem_sh[XLEN-1:0];
        q_fix  = negq ? -quo : quo;
        r_fix  = negr ? -rem : rem;
        sel    = op_q[1] ? r_fix : q_fix;
        res_nx = w_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; a fast request spends one BUSY cycle with zero iterations.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = BUSY;
            BUSY: begin
                if (i_flush)         state_nx = IDLE;
                else if (cnt == '0)  state_nx = DONE;
            end
            DONE: if (i_flush || i_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch request on accept, iterate in BUSY, register result on the last BUSY cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_q  <= '0;
            w_q   <= 1'b0;
            negq  <= 1'b0;
            negr  <= 1'b0;
            dvs   <= '0;
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
            res_q <= '0;
        end else if (accept) begin
            op_q <= i_op;
            w_q  <= i_i64;
            dvs  <= b_mag;
            if (fast) begin
                quo  <= fast_q;
                rem  <= fast_r;
                negq <= 1'b0;
                negr <= 1'b0;
                cnt  <= '0;
            end else begin
                // W forms start with the 32-bit magnitude in the top half so bit XLEN-1 feeds each step.
                quo  <= i_i64 ? {a_mag[31:0], 32'b0} : a_mag;
                rem  <= '0;
                negq <= a_neg ^ b_neg;
                negr <= a_neg;
                cnt  <= i_i64 ? CW'(XLEN/2) : CW'(XLEN);
            end
        end else if (state == BUSY && !i_flush) begin
            if (cnt != '0) begin
                quo <= {quo[XLEN-2:0], ge};
                rem <= rem_nx;
                cnt <= cnt - 1'b1;
            end else begin
                res_q <= res_nx;
            end
        end
    end

endmodule

// File: tb/tb_ch0re_div.sv
module tb_ch0re_div;

    logic        clk = 1'b0;
    logic        i_rst, i_flush, i_valid, o_ready, i_i64, o_valid, i_ready;
    logic [1:0]  i_op;
    logic [63:0] i_s1, i_s2, o_res;

    always #5 clk = ~clk;

    ch0re_div dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_i64   (i_i64),
        .i_s1    (i_s1),
        .i_s2    (i_s2),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   accept_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] prep(input logic w, input logic sg, input logic [63:0] s);
        if (!w) return s;
        return sg ? {{32{s[31]}}, s[31:0]} : {32'h0, s[31:0]};
    endfunction

    // Reference result using native division; RISC-V corner cases handled explicitly.
    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic w,
                                            input logic [63:0] s1, input logic [63:0] s2);
        logic        sg;
        logic [63:0] a, b, q, r, y;
        sg = ~op[0];
        a  = prep(w, sg, s1);
        b  = prep(w, sg, s2);
        if (b == 64'd0) begin
            q = '1; r = a;
        end else if (sg && b == '1) begin
            q = -a; r = 64'd0;
        end else if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        y = op[1] ? r : q;
        return w ? {{32{y[31]}}, y[31:0]} : y;
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic w,
                                   input logic [63:0] s1, input logic [63:0] s2);
        logic        sg;
        logic [63:0] a, b, am, bm, mn;
        sg = ~op[0];
        a  = prep(w, sg, s1);
        b  = prep(w, sg, s2);
        mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        am = (sg && a[63]) ? -a : a;
        bm = (sg && b[63]) ? -b : b;
        if (b == 64'd0 || (sg && b == '1 && a == mn)) return 1;
`ifdef CH0RE_DIV_EARLY_OUT_EN
        if (am < bm) return 1;
`else
        if (am == 64'd1 && bm == 64'd0) return 0;
`endif
        return w ? 33 : 65;
    endfunction

    task automatic start(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        chk("ready_before_accept", {63'd0, o_ready}, 64'd1);
        i_valid = 1'b1; i_op = op; i_i64 = w; i_s1 = a; i_s2 = b;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        // Scramble inputs: the unit must have latched them.
        i_valid = 1'b0; i_op = ~op; i_i64 = ~w; i_s1 = ~a; i_s2 = a ^ b;
    endtask

    task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] res, input int lat);
        exp_t e;
        e.res = res;
        e.lat = lat;
        sb.push_back(e);
        start(op, w, a, b);
    endtask

    task automatic issue_m(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        issue(op, w, a, b, ref_res(op, w, a, b), ref_lat(op, w, a, b));
    endtask

    task automatic wait_res(input string tag);
        exp_t e;
        int   g = 0;
        while (o_valid !== 1'b1 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk({tag, "_vld"}, {63'd0, o_valid}, 64'd1);
        e = sb.pop_front();
        chk({tag, "_res"}, o_res, e.res);
        chk({tag, "_lat"}, 64'(cyc - accept_cyc), 64'(e.lat));
    endtask

    task automatic handoff(input string tag);
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        chk({tag, "_ho_vld"}, {63'd0, o_valid}, 64'd0);
        chk({tag, "_ho_rdy"}, {63'd0, o_ready}, 64'd1);
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] res, input int lat);
        issue(op, w, a, b, res, lat);
        wait_res(tag);
        handoff(tag);
    endtask

    // Long op that gets killed at iteration 10 by flush (use_rst=0) or reset (use_rst=1), then recovery.
    task automatic kill_test(input string tag, input logic use_rst);
        logic seen;
        start(2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        if (use_rst) i_rst = 1'b1; else i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        i_flush = 1'b0;
        chk({tag, "_vld"}, {63'd0, o_valid}, 64'd0);
        chk({tag, "_rdy"}, {63'd0, o_ready}, 64'd1);
        if (use_rst) chk({tag, "_res0"}, o_res, 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (o_valid) seen = 1'b1;
        end
        chk({tag, "_never_vld"}, {63'd0, seen}, 64'd0);
        run({tag, "_recover"}, 2'd1, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    endtask

    initial begin
        i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_op = 2'd0; i_i64 = 1'b0; i_s1 = '0; i_s2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", {63'd0, o_valid}, 64'd0);
        chk("rst_rdy", {63'd0, o_ready}, 64'd1);
        chk("rst_res", o_res, 64'd0);
        i_rst = 1'b0;

        run("div_neg",  2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
        run("rem_neg",  2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run("divu_z",   2'd1, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run("remu_z",   2'd3, 1'b0, 64'h1234, 64'd0, 64'h1234, 1);
        run("div_ovf",  2'd0, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run("rem_ovf",  2'd2, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        run("divuw",    2'd1, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
        run("divw",     2'd0, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run("divw_ovf", 2'd0, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 1);

        // Flush in IDLE must block the accept.
        @(negedge clk);
        i_valid = 1'b1; i_flush = 1'b1; i_s1 = 64'd9; i_s2 = 64'd2;
        @(posedge clk);
        #1;
        i_valid = 1'b0; i_flush = 1'b0;
        chk("idle_flush_rdy", {63'd0, o_ready}, 64'd1);

        // Backpressure: result held while i_ready low, no accept during DONE or at the handoff edge.
        issue(2'd1, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        wait_res("bp");
        @(negedge clk);
        i_valid = 1'b1; i_op = 2'd1; i_i64 = 1'b0; i_s1 = 64'd50; i_s2 = 64'd5;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_vld", {63'd0, o_valid}, 64'd1);
            chk("bp_res", o_res, 64'd14);
            chk("bp_rdy", {63'd0, o_ready}, 64'd0);
        end
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        chk("bp_ho_vld", {63'd0, o_valid}, 64'd0);
        chk("bp_ho_rdy", {63'd0, o_ready}, 64'd1);
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_no_accept", {63'd0, o_ready}, 64'd1);

        kill_test("flush", 1'b0);
        kill_test("rstbusy", 1'b1);

        // Randomised mix checked against the reference model.
        for (int k = 0; k < 20; k++) begin
            logic [1:0]  op;
            logic        w;
            logic [63:0] a, b;
            op = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = {$urandom, $urandom};
                1:       b = 64'($urandom_range(1, 15));
                2:       b = 64'd0;
                default: begin a = 64'($urandom_range(0, 50)); b = {$urandom, $urandom}; end
            endcase
            issue_m(op, w, a, b);
            wait_res("rand");
            handoff("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
